// File: rtl/riscv_prog_sequencer.sv
// Program sequencer and self-checker: issues stored instructions to an RV32I core and scores each writeback.
// Optional MISMATCH_STOP_EN: the first failure (mismatch or timeout) ends the run with halted = 1.
module riscv_prog_sequencer #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [XLEN-1:0]   load_inst,
    input  logic [XLEN-1:0]   load_expect,
    input  logic              load_check,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    output logic [XLEN-1:0]   inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic [XLEN-1:0]   result,
    input  logic              result_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pass_cnt,
    output logic [ADDR_W:0]   fail_cnt,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic              first_fail_valid,
    output logic              timeout_seen,
    output logic              halted
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic            check;
        logic [XLEN-1:0] expected;
        logic [XLEN-1:0] inst;
    } entry_t;

    state_t             state;
    state_t             nxt;
    entry_t             mem [DEPTH];
    entry_t             cur;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  last_idx;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   eff_len;

    logic start_run;
    logic accept;
    logic in_wait;
    logic rsp;
    logic tmo;
    logic entry_done;
    logic hit;
    logic miss;
    logic fail_ev;
    logic stop_ev;
    logic last;

    // Program memory is deliberately not reset so a run can be repeated after a reset.
    always_ff @(posedge sysclk) begin
        if (load_en && !busy) begin
            mem[load_addr] <= '{check: load_check, expected: load_expect, inst: load_inst};
        end
    end

    assign cur = mem[pc];

    // Event decode for the current cycle.
    always_comb begin
        start_run  = start && ((state == ST_IDLE) || (state == ST_DONE));
        accept     = (state == ST_ISSUE) && inst_ready;
        in_wait    = (state == ST_WAIT);
        rsp        = in_wait && result_valid;
        tmo        = in_wait && !result_valid && (timer == TMR_W'(TIMEOUT - 1));
        entry_done = rsp || tmo;
        hit        = rsp && cur.check && (result == cur.expected);
        miss       = rsp && cur.check && (result != cur.expected);
        fail_ev    = miss || tmo;
        last       = (pc == last_idx);
        eff_len    = (prog_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : prog_len;
    end

`ifdef MISMATCH_STOP_EN
    assign stop_ev = fail_ev;
`else
    assign stop_ev = 1'b0;
`endif

    // State register; busy/done are registered copies of the next state.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= (nxt == ST_ISSUE) || (nxt == ST_WAIT);
            done  <= (nxt == ST_DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_run) begin
                    nxt = (prog_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (inst_ready) begin
                    nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (entry_done) begin
                    nxt = (last || stop_ev) ? ST_DONE : ST_ISSUE;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Core-facing handshake is combinational from state and pc so inst is presented in the ISSUE cycle.
    always_comb begin
        inst_valid = 1'b0;
        inst       = '0;
        if (state == ST_ISSUE) begin
            inst_valid = 1'b1;
            inst       = cur.inst;
        end
    end

    // Run datapath: pc, timer and scoreboard counters.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            pc               <= '0;
            last_idx         <= '0;
            timer            <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            timeout_seen     <= 1'b0;
        end else if (start_run) begin
            pc               <= '0;
            last_idx         <= ADDR_W'(eff_len - CNT_W'(1));
            timer            <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            timeout_seen     <= 1'b0;
        end else begin
            if (accept) begin
                timer <= '0;
            end else if (in_wait) begin
                timer <= timer + TMR_W'(1);
            end
            if (hit) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (fail_ev) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
            if (tmo) begin
                timeout_seen <= 1'b1;
            end
            if (fail_ev && !first_fail_valid) begin
                first_fail_idx   <= pc;
                first_fail_valid <= 1'b1;
            end
            // On an early stop pc keeps the failing index.
            if (entry_done && !last && !stop_ev) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

`ifdef MISMATCH_STOP_EN
    logic halted_q;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            halted_q <= 1'b0;
        end else if (start_run) begin
            halted_q <= 1'b0;
        end else if (stop_ev) begin
            halted_q <= 1'b1;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_prog_sequencer.sv
// Self-checking bench for riscv_prog_sequencer: a core model answers issued instructions,
// a scoreboard holds expected issue words and per-run results computed from a shadow program.
module tb_riscv_prog_sequencer;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned TIMEOUT = 15;
    localparam int          LIMIT   = 2000;

    logic              sysclk = 1'b0;
    logic              sysreset;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [XLEN-1:0]   load_inst;
    logic [XLEN-1:0]   load_expect;
    logic              load_check;
    logic [CNT_W-1:0]  prog_len;
    logic              start;
    logic [XLEN-1:0]   inst;
    logic              inst_valid;
    logic              inst_ready;
    logic [XLEN-1:0]   result;
    logic              result_valid;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic [ADDR_W-1:0] first_fail_idx;
    logic              first_fail_valid;
    logic              timeout_seen;
    logic              halted;

    riscv_prog_sequencer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .load_en(load_en), .load_addr(load_addr), .load_inst(load_inst),
        .load_expect(load_expect), .load_check(load_check),
        .prog_len(prog_len), .start(start),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .result(result), .result_valid(result_valid),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid),
        .timeout_seen(timeout_seen), .halted(halted)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int pass;
        int fail;
        int ffv;
        int ffi;
        int tos;
        int hlt;
        int issued;
    } run_exp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_inst_q[$];
    run_exp_t    run_q[$];

    // Shadow program and per-entry core behaviour (dly 0 = never answer).
    logic [31:0] sh_inst [DEPTH];
    logic [31:0] sh_exp  [DEPTH];
    logic        sh_chk  [DEPTH];
    logic [31:0] rsp_val [DEPTH];
    int          rsp_dly [DEPTH];
    int          rsp_stall [DEPTH];
    int          issue_idx = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({inst, inst_valid, busy, done, pass_cnt, fail_cnt,
                    first_fail_idx, first_fail_valid, timeout_seen, halted});
    endfunction

    task automatic load(input int idx, input logic [31:0] i, input logic [31:0] e, input logic c);
        load_en = 1'b1; load_addr = ADDR_W'(idx); load_inst = i; load_expect = e; load_check = c;
        @(negedge sysclk);
        load_en = 1'b0;
        sh_inst[idx] = i; sh_exp[idx] = e; sh_chk[idx] = c;
    endtask

    task automatic set_rsp(input int idx, input logic [31:0] v, input int dly, input int stall);
        rsp_val[idx] = v; rsp_dly[idx] = dly; rsp_stall[idx] = stall;
    endtask

    // Core model: accepts after the entry's stall count, answers dly cycles into WAIT.
    initial begin : core_model
        bit pending = 0;
        int wcnt = 0;
        int stall_cnt = 0;
        int cur_idx = 0;
        inst_ready = 1'b0; result_valid = 1'b0; result = '0;
        forever begin
            @(negedge sysclk);
            inst_ready = 1'b0; result_valid = 1'b0; result = $urandom;
            if (sysreset) begin
                pending = 0; stall_cnt = 0;
            end else if (pending) begin
                wcnt++;
                if (wcnt == 1) check("inst_valid_in_wait", 64'(inst_valid), 64'd0);
                if (wcnt == rsp_dly[cur_idx]) begin
                    result_valid = 1'b1; result = rsp_val[cur_idx];
                end
                if (wcnt == rsp_dly[cur_idx] || wcnt >= int'(TIMEOUT)) pending = 0;
            end else if (inst_valid) begin
                if (exp_inst_q.size() == 0) begin
                    check("unexpected_issue", 64'd1, 64'd0);
                end else begin
                    if (stall_cnt == 0) check("inst", 64'(inst), 64'(exp_inst_q[0]));
                    else check("inst_stable", 64'(inst), 64'(exp_inst_q[0]));
                    if (stall_cnt < rsp_stall[issue_idx]) begin
                        stall_cnt++;
                    end else begin
                        inst_ready = 1'b1;
                        void'(exp_inst_q.pop_front());
                        cur_idx = issue_idx; issue_idx++;
                        pending = 1; wcnt = 0; stall_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic run_prog(input int len, input int abort_after, input bit poke, output int cycles);
        run_exp_t e;
        int n;
        bit bad;
        e = '{default: 0};
        n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        for (int i = 0; i < n; i++) begin
            e.issued++;
            exp_inst_q.push_back(sh_inst[i]);
            bad = 0;
            if (rsp_dly[i] == 0 || rsp_dly[i] > int'(TIMEOUT)) begin
                e.fail++; e.tos = 1; bad = 1;
            end else if (sh_chk[i]) begin
                if (rsp_val[i] == sh_exp[i]) e.pass++;
                else begin e.fail++; bad = 1; end
            end
            if (bad && e.ffv == 0) begin e.ffv = 1; e.ffi = i; end
`ifdef MISMATCH_STOP_EN
            if (bad) begin e.hlt = 1; break; end
`endif
        end
        run_q.push_back(e);
        issue_idx = 0;
        prog_len = CNT_W'(len);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        cycles = 1;
        if (poke) begin
            load_en = 1'b1; load_addr = '0; load_inst = 32'hFFFF_FFFF;
            load_expect = 32'h1234_5678; load_check = 1'b1;
            @(negedge sysclk);
            load_en = 1'b0;
            cycles++;
        end
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge sysclk);
            #2 sysreset = 1'b1;
            #1 check("abort_outputs_zero", all_outputs(), 64'd0);
            repeat (2) @(negedge sysclk);
            sysreset = 1'b0;
            exp_inst_q.delete();
            void'(run_q.pop_back());
            return;
        end
        while (!done && cycles < LIMIT) begin
            @(negedge sysclk);
            cycles++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
        e = run_q.pop_front();
        check("pass_cnt", 64'(pass_cnt), 64'(e.pass));
        check("fail_cnt", 64'(fail_cnt), 64'(e.fail));
        check("first_fail_valid", 64'(first_fail_valid), 64'(e.ffv));
        check("first_fail_idx", 64'(first_fail_idx), 64'(e.ffi));
        check("timeout_seen", 64'(timeout_seen), 64'(e.tos));
        check("halted", 64'(halted), 64'(e.hlt));
        check("busy_after_done", 64'(busy), 64'd0);
        check("issued", 64'(issue_idx), 64'(e.issued));
    endtask

    initial begin : main
        int cyc;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sh_inst[i] = '0; sh_exp[i] = '0; sh_chk[i] = 1'b0;
            set_rsp(i, 32'd0, 1, 0);
        end
        sysreset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0;
        load_inst = '0; load_expect = '0; load_check = 1'b0; prog_len = '0;
        #2 check("reset_outputs_zero", all_outputs(), 64'd0);
        repeat (2) @(negedge sysclk);
        sysreset = 1'b0;

        // Single addi, answered one cycle after accept.
        load(0, 32'h0070_0093, 32'd7, 1'b1);
        set_rsp(0, 32'd7, 1, 0);
        run_prog(1, 0, 0, cyc);
        check("single_latency", 64'(cyc), 64'd3);
        check("done_held", 64'(done), 64'd1);

        // Three entries, middle result wrong.
        load(1, 32'h0050_0113, 32'd5, 1'b1);
        load(2, 32'h0090_0193, 32'd9, 1'b1);
        set_rsp(1, 32'd6, 2, 0);
        set_rsp(2, 32'd9, 1, 0);
        run_prog(3, 0, 0, cyc);

        // Same program with a 5-cycle ready stall; a load while busy must be dropped.
        set_rsp(0, 32'd7, 1, 5);
        run_prog(3, 0, 1, cyc);
        set_rsp(0, 32'd7, 1, 0);
        run_prog(3, 0, 0, cyc);

        // Timeouts: never, exactly at the limit (result wins), one past the limit.
        load(0, 32'h0010_0093, 32'd1, 1'b1);
        load(1, 32'h0020_0113, 32'd2, 1'b1);
        load(2, 32'h0030_0193, 32'd3, 1'b1);
        load(3, 32'h0040_0213, 32'd4, 1'b1);
        set_rsp(0, 32'd1, 0, 0);
        set_rsp(1, 32'd2, int'(TIMEOUT), 0);
        set_rsp(2, 32'd3, int'(TIMEOUT) + 1, 0);
        set_rsp(3, 32'd4, 1, 0);
        run_prog(4, 0, 0, cyc);

        // Unchecked entry returning junk, then an empty run.
        load(0, 32'h0050_0293, 32'd5, 1'b0);
        load(1, 32'h0060_0313, 32'd6, 1'b1);
        set_rsp(0, 32'h0000_DEAD, 1, 0);
        set_rsp(1, 32'd6, 3, 0);
        run_prog(2, 0, 0, cyc);
        run_prog(0, 0, 0, cyc);
        check("len0_latency", 64'(cyc), 64'd1);
        check("len0_done", 64'(done), 64'd1);

        // prog_len above DEPTH clamps to DEPTH; a few mismatches sprinkled in.
        for (int i = 0; i < int'(DEPTH); i++) begin
            load(i, $urandom, 32'(i * 3), 1'b1);
            set_rsp(i, (i % 5 == 4) ? 32'(i * 3 + 1) : 32'(i * 3), 1 + (i % 3), 0);
        end
        run_prog(20, 0, 0, cyc);

        // Reload the three-entry program, abort mid-WAIT, rerun from retained memory.
        load(0, 32'h0070_0093, 32'd7, 1'b1);
        load(1, 32'h0050_0113, 32'd5, 1'b1);
        load(2, 32'h0090_0193, 32'd9, 1'b1);
        set_rsp(0, 32'd7, 1, 0);
        set_rsp(1, 32'd6, 2, 0);
        set_rsp(2, 32'd9, 1, 0);
        run_prog(3, 0, 0, cyc);
        set_rsp(0, 32'd7, 8, 0);
        run_prog(3, 4, 0, cyc);
        check("idle_after_abort", 64'({busy, done}), 64'd0);
        set_rsp(0, 32'd7, 1, 0);
        run_prog(3, 0, 0, cyc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_prog_sequencer.md
Name: riscv_prog_sequencer

Overview:
Synthesizable program sequencer and self-checker for the RV32I core. It stores up to DEPTH instruction words, each with an expected writeback value and a check flag. On start it issues the instructions to the core one at a time and compares each returned result against its expected value. It also counts passes and failures and records the first failing index. It replaces hand-driven instruction stimulus with a reusable block that can be instantiated in simulation or on the board.

Parameters:
XLEN, 32, instruction and result width
DEPTH, 16, number of program entries (power of 2, >=2)
ADDR_W, $clog2(DEPTH), entry index width
TIMEOUT, 15, maximum WAIT-state cycles allowed per instruction before it is scored as a failure

Ports:
sysclk  in  1  clock, rising edge
sysreset  in  1  reset, asynchronous, active-high
load_en  in  1  write one program entry at load_addr; ignored while busy
load_addr  in  ADDR_W  entry index
load_inst  in  XLEN  instruction word
load_expect  in  XLEN  expected result
load_check  in  1  1 = compare this entry's result
prog_len  in  ADDR_W+1  number of entries to run, sampled on start
start  in  1  begin run; ignored while busy
inst  out  XLEN  instruction presented to core
inst_valid  out  1  inst is valid
inst_ready  in  1  core accepts inst this cycle
result  in  XLEN  core writeback value
result_valid  in  1  result valid this cycle
busy  out  1  run in progress
done  out  1  run complete; held until the next start
pass_cnt  out  ADDR_W+1  checked entries that matched
fail_cnt  out  ADDR_W+1  checked mismatches plus timeouts
first_fail_idx  out  ADDR_W  index of the first failure
first_fail_valid  out  1  first_fail_idx is meaningful
timeout_seen  out  1  at least one timeout occurred in this run
halted  out  1  run stopped early on a mismatch (MISMATCH_STOP_EN only)

Behaviour:
- Reset values (asynchronous, active-high): every output is 0, the FSM is in IDLE, pc = 0, the timer is 0. The program memory is not reset.
- Program memory:
  - Synchronous write: on load_en && !busy, entry[load_addr] <= {load_check, load_expect, load_inst}.
  - load_en while busy is dropped silently.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE or DONE, on start:
  - Latch prog_len.
  - Clear pc, pass_cnt, fail_cnt, first_fail_*, timeout_seen, halted and done.
  - If prog_len == 0, go to DONE with counts 0. Otherwise go to ISSUE.
- ISSUE:
  - inst_valid = 1 and inst = entry[pc].inst, driven combinationally from pc.
  - On inst_valid && inst_ready, go to WAIT and clear the timer.
  - inst holds stable until accepted.
  - result_valid is ignored in this state.
- WAIT:
  - inst_valid = 0; the timer increments each cycle.
  - On result_valid with check = 1: if result == expect, pass_cnt++; otherwise fail_cnt++.
  - On result_valid with check = 0: no count change.
  - If the timer reaches TIMEOUT with no result_valid: fail_cnt++ and timeout_seen = 1; treat as a completed entry.
  - If result_valid and the timeout occur in the same cycle, result_valid wins.
  - On entry completion: if pc == len-1, go to DONE; otherwise pc++ and go to ISSUE.
- First failure: first_fail_idx and first_fail_valid are written only on the first failure of a run.
- Status outputs:
  - busy = 1 in ISSUE and WAIT.
  - done = 1 in DONE and stays asserted until start or reset.
- Latency: minimum 2 cycles per entry (ISSUE accept, then WAIT with result the next cycle).
- Counters cannot overflow: their width is ADDR_W+1 and runs are at most DEPTH entries.
- prog_len > DEPTH is clamped to DEPTH.
- sysreset mid-run aborts immediately to IDLE with all outputs 0; program memory contents are retained.

Optional Feature:
MISMATCH_STOP_EN
- Defined: the first failure (mismatch or timeout) ends the run immediately. The FSM goes to DONE with halted = 1, and pc keeps the failing index.
- Undefined: halted is tied to 0 and the run always completes all prog_len entries.

Test Plan:
- Load entry0 = 0x00700093 (addi x1,x0,7), expect 7, check = 1; prog_len = 1; start; core answers result = 7 one cycle after accept -> inst = 0x00700093 while inst_valid; done = 1, pass_cnt = 1, fail_cnt = 0, first_fail_valid = 0.
- 3 entries, expects 7/5/9, core returns 7/6/9; MISMATCH_STOP_EN undefined -> pass_cnt = 2, fail_cnt = 1, first_fail_idx = 1, done = 1. With MISMATCH_STOP_EN defined -> halted = 1, pass_cnt = 1, fail_cnt = 1, entry 2 never issued.
- Hold inst_ready = 0 for 5 cycles, then 1 -> inst_valid stays 1 and inst stays stable for 5 cycles; no timer advance and no count change.
- Entry 0 never gets result_valid; TIMEOUT = 15 -> after 15 WAIT cycles fail_cnt = 1, timeout_seen = 1, run proceeds to entry 1.
- Entry with check = 0 and result 0xDEAD -> counts unchanged; prog_len = 0 start -> done next cycle, counts 0.
- Assert sysreset asynchronously mid-WAIT, then restart without reloading -> all outputs 0 during reset; rerun gives the same pass_cnt as the first run, confirming memory retained.
